// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download transmitter: FSM state encoding
// and the file-index numbering used by the loaders.
package ioctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_STROBE = 3'd3,
    ST_GAP    = 3'd4,
    ST_TRAIL  = 3'd5
  } ioctl_xmit_state_t;

  // Index 0..IOCTL_IDX_ROM_MAX are ROM slots; the rest are media types.
  localparam logic [7:0] IOCTL_IDX_ROM_MAX = 8'd3;
  localparam logic [7:0] IOCTL_IDX_TAPE    = 8'd4;
  localparam logic [7:0] IOCTL_IDX_CPR     = 8'd5;
  localparam logic [7:0] IOCTL_IDX_BIN     = 8'd6;

endpackage

// File: rtl/ioctl_xmit.sv
// Transmitter side of the ioctl download interface. Converts a valid/ready
// byte stream into ioctl_wr strobes framed by ioctl_download, with a lead-in
// window, a minimum spacing between strobes and a trailing window.
module ioctl_xmit
  import ioctl_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int LEAD   = 8,
  parameter int WR_GAP = 4,
  parameter int TRAIL  = 8
) (
  input  logic              clk_48,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  // One down-counter serves LEAD, GAP and TRAIL, so it is sized for the
  // longest of the three phases.
  localparam int PH_MAX = (LEAD > WR_GAP) ? ((LEAD > TRAIL) ? LEAD : TRAIL)
                                          : ((WR_GAP > TRAIL) ? WR_GAP : TRAIL);
  localparam int PH_W = $clog2(PH_MAX + 1);

  // Load values are "cycles minus one": the phase ends when the counter is 0.
  // GAP lasts WR_GAP-1 cycles, hence the extra minus one.
  localparam logic [PH_W-1:0] LEAD_LD  = PH_W'(LEAD - 1);
  localparam logic [PH_W-1:0] GAP_LD   = PH_W'(WR_GAP - 2);
  localparam logic [PH_W-1:0] TRAIL_LD = PH_W'(TRAIL - 1);

  ioctl_xmit_state_t state_q;
  logic [PH_W-1:0]   phase_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] len_q;
  logic [7:0]        index_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout_q;
  logic              download_q;
  logic              wr_q;
  logic              s_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic [ADDR_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + ADDR_W'(1);

  // The only combinational output path: core back-pressure gates the
  // registered "ready in FETCH" flag. abort is resolved inside the FSM so it
  // does not reach s_ready combinationally; a source that sees abort should
  // treat its in-flight byte as dropped.
  assign s_ready = s_ready_q & ~ioctl_wait;

  assign ioctl_download = download_q;
  assign ioctl_index    = index_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;

  // Transfer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      index_q    <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      download_q <= 1'b0;
      wr_q       <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            index_q    <= index;
            len_q      <= length;
            cnt_q      <= '0;
            aborted_q  <= 1'b0;
            download_q <= 1'b1;
            busy_q     <= 1'b1;
            phase_q    <= LEAD_LD;
            state_q    <= ST_LEAD;
          end
        end

        ST_LEAD: begin
          if (abort) begin
            aborted_q <= 1'b1;
            phase_q   <= TRAIL_LD;
            state_q   <= ST_TRAIL;
          end else if (phase_q == '0) begin
            if (len_q == '0) begin
              // Empty transfer: full window, no strobes, reported as aborted.
              aborted_q <= 1'b1;
              phase_q   <= TRAIL_LD;
              state_q   <= ST_TRAIL;
            end else begin
              s_ready_q <= 1'b1;
              state_q   <= ST_FETCH;
            end
          end else begin
            phase_q <= phase_q - PH_W'(1);
          end
        end

        ST_FETCH: begin
          if (abort) begin
            // A byte offered in the abort cycle is deliberately not taken.
            s_ready_q <= 1'b0;
            aborted_q <= 1'b1;
            phase_q   <= TRAIL_LD;
            state_q   <= ST_TRAIL;
          end else if (s_valid && s_ready) begin
            dout_q    <= s_data;
            addr_q    <= cnt_q;
            wr_q      <= 1'b1;
            s_ready_q <= 1'b0;
            state_q   <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          // The strobe is already on the wire; abort only shortens what follows.
          cnt_q <= cnt_inc;
          if (cnt_inc == len_q) begin
            phase_q <= TRAIL_LD;
            state_q <= ST_TRAIL;
          end else if (abort) begin
            aborted_q <= 1'b1;
            phase_q   <= TRAIL_LD;
            state_q   <= ST_TRAIL;
          end else begin
            phase_q <= GAP_LD;
            state_q <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (abort) begin
            aborted_q <= 1'b1;
            phase_q   <= TRAIL_LD;
            state_q   <= ST_TRAIL;
          end else if (phase_q == '0) begin
            s_ready_q <= 1'b1;
            state_q   <= ST_FETCH;
          end else begin
            phase_q <= phase_q - PH_W'(1);
          end
        end

        ST_TRAIL: begin
          if (phase_q == '0) begin
            download_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            phase_q <= phase_q - PH_W'(1);
          end
        end

        default: begin
          download_q <= 1'b0;
          s_ready_q  <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_xmit.sv
// Directed bench for ioctl_xmit with default parameters
// (LEAD=8, WR_GAP=4, TRAIL=8, ADDR_W=25).
module tb_ioctl_xmit;

  localparam int AW    = 25;
  localparam int LEAD  = 8;
  localparam int GAP   = 4;
  localparam int TRAIL = 8;

  logic          clk_48 = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    index;
  logic [AW-1:0] length;
  logic          abort;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic          busy;
  logic          done;
  logic          aborted;

  ioctl_xmit #(.ADDR_W(AW), .LEAD(LEAD), .WR_GAP(GAP), .TRAIL(TRAIL)) dut (
    .clk_48(clk_48), .reset(reset), .start(start), .index(index),
    .length(length), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .busy(busy),
    .done(done), .aborted(aborted)
  );

  always #5 clk_48 = ~clk_48;

  int checks = 0;
  int failures = 0;

  // Passive monitor, sampled on the falling edge.
  int          cyc = 0;
  int          stb_n, done_n, rise_cyc, fall_cyc, start_cyc, last_wait_cyc;
  int          wr_in_wait, idx_bad;
  logic [AW-1:0] stb_addr [256];
  logic [7:0]  stb_dout [256];
  int          stb_cyc  [256];
  logic        dl_prev = 1'b0;
  logic [7:0]  exp_idx = 8'd0;

  always @(negedge clk_48) begin
    cyc = cyc + 1;
    if (start && !busy) start_cyc = cyc;
    if (ioctl_wr) begin
      if (stb_n < 256) begin
        stb_addr[stb_n] = ioctl_addr;
        stb_dout[stb_n] = ioctl_dout;
        stb_cyc[stb_n]  = cyc;
      end
      stb_n = stb_n + 1;
      if (ioctl_wait) wr_in_wait = wr_in_wait + 1;
    end
    if (ioctl_wait) last_wait_cyc = cyc;
    if (done) done_n = done_n + 1;
    if (ioctl_download && !dl_prev) rise_cyc = cyc;
    if (!ioctl_download && dl_prev) fall_cyc = cyc;
    dl_prev = ioctl_download;
    if (ioctl_download && ioctl_index !== exp_idx) idx_bad = idx_bad + 1;
  end

  // Byte source: presents src[0]; optional idle gaps of 1..7,0 cycles.
  logic [7:0] src [$];
  logic       gap_en = 1'b0;
  int         sent = 0;

  initial begin
    logic take;
    int   gap_cnt;
    gap_cnt = 0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    forever begin
      @(negedge clk_48);
      take = s_valid && s_ready && !abort;
      @(posedge clk_48);
      #1;
      if (take && src.size() > 0) begin
        void'(src.pop_front());
        sent = sent + 1;
        gap_cnt = gap_en ? (sent % 8) : 0;
      end
      if (gap_cnt > 0) begin
        gap_cnt = gap_cnt - 1;
        s_valid = 1'b0;
      end else if (src.size() > 0) begin
        s_valid = 1'b1;
        s_data  = src[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    stb_n = 0; done_n = 0; rise_cyc = -1; fall_cyc = -1; start_cyc = -1;
    last_wait_cyc = -1; wr_in_wait = 0; idx_bad = 0;
  endtask

  task automatic do_start(input logic [7:0] idx, input logic [AW-1:0] len);
    @(posedge clk_48); #1;
    exp_idx = idx;
    index   = idx;
    length  = len;
    start   = 1'b1;
    @(posedge clk_48); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_n == 0 && n < 3000) begin
      @(posedge clk_48); #1;
      n++;
    end
    checks++;
    if (done_n == 0) begin
      failures++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", tag, n);
    end
    repeat (3) @(posedge clk_48);
    #1;
  endtask

  task automatic wait_strobes(input int k, input string tag);
    int n;
    n = 0;
    while (stb_n < k && n < 3000) begin
      @(posedge clk_48); #1;
      n++;
    end
    checks++;
    if (stb_n < k) begin
      failures++;
      $display("FAIL %s_strobe_timeout: got %0d strobes, required %0d", tag, stb_n, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; index = 8'd0; length = '0;
    abort = 1'b0; ioctl_wait = 1'b0;
    repeat (3) @(posedge clk_48);
    #1;
    checks++;
    if ({ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
         s_ready, busy, done, aborted} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: dl=%b wr=%b addr=%0d dout=%0d idx=%0d rdy=%b busy=%b done=%b ab=%b, required all 0",
               ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
               s_ready, busy, done, aborted);
    end
    reset = 1'b0;
    @(posedge clk_48); #1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd11; exp_d[1] = 8'd22; exp_d[2] = 8'd33; exp_d[3] = 8'd44;
    clear_mon();
    gap_en = 1'b0;
    for (int i = 0; i < 4; i++) src.push_back(exp_d[i]);
    do_start(8'd5, AW'(4));
    wait_done("basic");
    checks++;
    if (stb_n !== 4) begin
      failures++;
      $display("FAIL basic_count: got %0d strobes, required 4", stb_n);
    end
    for (int i = 0; i < 4 && i < stb_n; i++) begin
      checks++;
      if (stb_addr[i] !== AW'(i) || stb_dout[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL basic_strobe%0d: addr=%0d dout=%0d, required addr=%0d dout=%0d",
                 i, stb_addr[i], stb_dout[i], i, exp_d[i]);
      end
      if (i > 0) begin
        checks++;
        if (stb_cyc[i] - stb_cyc[i-1] != GAP + 1) begin
          failures++;
          $display("FAIL basic_spacing%0d: got %0d cycles, required %0d",
                   i, stb_cyc[i] - stb_cyc[i-1], GAP + 1);
        end
      end
    end
    checks++;
    if (rise_cyc - start_cyc != 1) begin
      failures++;
      $display("FAIL basic_rise: download rose %0d cycles after start, required 1", rise_cyc - start_cyc);
    end
    checks++;
    if (stb_n > 0 && stb_cyc[0] - start_cyc != LEAD + 2) begin
      failures++;
      $display("FAIL basic_first_strobe: %0d cycles after start, required %0d",
               stb_cyc[0] - start_cyc, LEAD + 2);
    end
    checks++;
    if (stb_n == 4 && fall_cyc - stb_cyc[3] != TRAIL + 1) begin
      failures++;
      $display("FAIL basic_trail: download fell %0d cycles after last strobe, required %0d",
               fall_cyc - stb_cyc[3], TRAIL + 1);
    end
    checks++;
    if (done_n !== 1 || aborted !== 1'b0 || idx_bad !== 0 || ioctl_index !== 8'd5) begin
      failures++;
      $display("FAIL basic_status: done_n=%0d aborted=%b idx_bad=%0d idx=%0d, required 1/0/0/5",
               done_n, aborted, idx_bad, ioctl_index);
    end
  endtask

  task automatic test_wait();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd11; exp_d[1] = 8'd22; exp_d[2] = 8'd33; exp_d[3] = 8'd44;
    clear_mon();
    for (int i = 0; i < 4; i++) src.push_back(exp_d[i]);
    do_start(8'd5, AW'(4));
    wait_strobes(1, "wait");
    ioctl_wait = 1'b1;
    repeat (20) @(posedge clk_48);
    #1;
    ioctl_wait = 1'b0;
    checks++;
    if (stb_n !== 1) begin
      failures++;
      $display("FAIL wait_hold: got %0d strobes while wait high, required 1", stb_n);
    end
    wait_done("wait");
    checks++;
    if (stb_n !== 4 || wr_in_wait !== 0) begin
      failures++;
      $display("FAIL wait_count: strobes=%0d wr_in_wait=%0d, required 4/0", stb_n, wr_in_wait);
    end
    checks++;
    if (stb_n >= 2 && (stb_cyc[1] < last_wait_cyc + 2 || stb_addr[1] !== AW'(1))) begin
      failures++;
      $display("FAIL wait_resume: strobe2 cyc=%0d addr=%0d, required cyc>=%0d addr=1",
               stb_cyc[1], stb_addr[1], last_wait_cyc + 2);
    end
    for (int i = 0; i < 4 && i < stb_n; i++) begin
      checks++;
      if (stb_addr[i] !== AW'(i) || stb_dout[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL wait_strobe%0d: addr=%0d dout=%0d, required addr=%0d dout=%0d",
                 i, stb_addr[i], stb_dout[i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_zero_length();
    clear_mon();
    do_start(8'd6, AW'(0));
    wait_done("zero");
    checks++;
    if (fall_cyc - rise_cyc != LEAD + TRAIL) begin
      failures++;
      $display("FAIL zero_window: download high %0d cycles, required %0d", fall_cyc - rise_cyc, LEAD + TRAIL);
    end
    checks++;
    if (stb_n !== 0 || done_n !== 1 || aborted !== 1'b1) begin
      failures++;
      $display("FAIL zero_status: strobes=%0d done_n=%0d aborted=%b, required 0/1/1", stb_n, done_n, aborted);
    end
  endtask

  task automatic test_abort();
    int m;
    clear_mon();
    for (int i = 0; i < 100; i++) src.push_back(8'(i + 1));
    do_start(8'd2, AW'(100));
    wait_strobes(10, "abort");
    m = stb_cyc[9];
    abort = 1'b1;
    @(posedge clk_48); #1;
    abort = 1'b0;
    wait_done("abort");
    src.delete();
    checks++;
    if (stb_n !== 10 || stb_addr[9] !== AW'(9) || ioctl_addr !== AW'(9)) begin
      failures++;
      $display("FAIL abort_strobes: strobes=%0d last_addr=%0d ioctl_addr=%0d, required 10/9/9",
               stb_n, stb_addr[9], ioctl_addr);
    end
    checks++;
    if (fall_cyc - m != TRAIL + 2) begin
      failures++;
      $display("FAIL abort_window: download fell %0d cycles after strobe 10, required %0d", fall_cyc - m, TRAIL + 2);
    end
    checks++;
    if (aborted !== 1'b1 || done_n !== 1) begin
      failures++;
      $display("FAIL abort_status: aborted=%b done_n=%0d, required 1/1", aborted, done_n);
    end
  endtask

  task automatic test_async_reset();
    clear_mon();
    for (int i = 0; i < 10; i++) src.push_back(8'(8'h50 + i));
    do_start(8'd1, AW'(10));
    wait_strobes(2, "rst");
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
         s_ready, busy, done, aborted} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs: dl=%b addr=%0d dout=%0d idx=%0d busy=%b, required all 0",
               ioctl_download, ioctl_addr, ioctl_dout, ioctl_index, busy);
    end
    src.delete();
    @(posedge clk_48); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk_48);
    #1;
    checks++;
    if (done_n !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_nodone: done_n=%0d busy=%b, required 0/0", done_n, busy);
    end
    clear_mon();
    for (int i = 0; i < 3; i++) src.push_back(8'(8'h70 + i));
    do_start(8'd3, AW'(3));
    wait_done("rst2");
    checks++;
    if (stb_n !== 3 || stb_addr[0] !== AW'(0) || stb_addr[2] !== AW'(2) ||
        stb_dout[0] !== 8'h70 || stb_dout[2] !== 8'h72 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL reset_restart: strobes=%0d a0=%0d a2=%0d d0=%0h d2=%0h ab=%b, required 3/0/2/70/72/0",
               stb_n, stb_addr[0], stb_addr[2], stb_dout[0], stb_dout[2], aborted);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    gap_en = 1'b1;
    sent = 0;
    for (int i = 0; i < 6; i++) src.push_back(8'(8'hA0 + i));
    do_start(8'd6, AW'(6));
    wait_strobes(1, "b2b");
    index  = 8'd9;
    length = AW'(2);
    start  = 1'b1;
    @(posedge clk_48); #1;
    start  = 1'b0;
    wait_done("b2b");
    repeat (30) @(posedge clk_48);
    #1;
    gap_en = 1'b0;
    checks++;
    if (stb_n !== 6 || done_n !== 1 || idx_bad !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_status: strobes=%0d done_n=%0d idx_bad=%0d busy=%b, required 6/1/0/0",
               stb_n, done_n, idx_bad, busy);
    end
    for (int i = 0; i < 6 && i < stb_n; i++) begin
      checks++;
      if (stb_addr[i] !== AW'(i) || stb_dout[i] !== 8'(8'hA0 + i)) begin
        failures++;
        $display("FAIL b2b_strobe%0d: addr=%0d dout=%0h, required addr=%0d dout=%0h",
                 i, stb_addr[i], stb_dout[i], i, 8'(8'hA0 + i));
      end
      if (i > 0) begin
        checks++;
        if (stb_cyc[i] - stb_cyc[i-1] < GAP + 1) begin
          failures++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, required >= %0d",
                   i, stb_cyc[i] - stb_cyc[i-1], GAP + 1);
        end
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_wait();
    test_zero_length();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
